display_scroll_ctrl: RTL

Parametrised successor of the multiplier's operator control unit. It conditions the raw Left/Centre/Right push-buttons (synchronise, debounce, edge-detect) and issues a one-cycle operand-load strobe to the datapath. It tracks calculation progress and drives a window-select code that scrolls the seven-segment display across NUM_WINDOWS result windows. It sits between the board buttons, the multiplier datapath and the display mux.

---
 rtl/mult_ctrl_pkg.sv | 26 ++
 rtl/button_conditioner.sv | 59 +++++
 rtl/display_scroll_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg
// Shared definitions for the operator control unit and its button
// conditioners.
//   state_t    - control FSM state encoding
//   WIN_BLANK  - window_sel code that blanks the seven-segment display
//   win_width  - width needed to hold window codes 0..num_windows
package mult_ctrl_pkg;

  // The encoding is fixed so that the state can be read back directly
  // during bring-up of the display mux.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    SHOW = 2'd3
  } state_t;

  localparam int WIN_BLANK = 0;

  // Window codes run from 0 (blank) up to num_windows inclusive, so the
  // select bus has to hold num_windows+1 distinct values.
  function automatic int win_width(input int num_windows);
    return $clog2(num_windows + 1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// button_conditioner
// Turns one raw, bouncy, asynchronous push-button into a clean accepted
// level and a single-cycle press pulse.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset
//   raw    - raw button input, asynchronous to clk
//   level  - debounced (accepted) button level
//   press  - one-cycle pulse on the accepted 0->1 transition; it is high
//            during the cycle that ends with level rising, so logic
//            clocked on that same edge sees the press
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] count;
  logic             at_limit;

  // The counter has seen the new level for the full debounce window.
  assign at_limit = (count == CNT_W'(DEBOUNCE_CYCLES));

  // A press is reported on the cycle where a high synchronised level is
  // about to be accepted; a release never produces a pulse.
  assign press = sync_b && !level && at_limit;

  // Two-flop synchroniser followed by the debounce counter. The counter
  // only runs while the synchronised input disagrees with the accepted
  // level, so any glitch shorter than the window clears it again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      count  <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sync_b == level) begin
        count <= '0;
      end else if (at_limit) begin
        level <= ~level;
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/display_scroll_ctrl.sv
// display_scroll_ctrl
// Operator control unit for the multiplier: conditions the three
// push-buttons, strobes an operand load into the datapath, tracks the
// calculation and scrolls the seven-segment display across the result
// windows.
// Ports:
//   clk          - system clock
//   rst_n        - synchronous active-low reset
//   btn_left     - raw button, scroll toward more-significant window
//   btn_center   - raw button, start a new calculation
//   btn_right    - raw button, scroll toward less-significant window
//   calc_done    - datapath done level, held until the next load
//   load_initial - one-cycle strobe telling the datapath to load operands
//   calculating  - high from the load strobe until the first calc_done
//   window_sel   - 0 blanks the display, 1..NUM_WINDOWS picks a window
//                  (1 = rightmost)
module display_scroll_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int NUM_WINDOWS     = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit WRAP            = 1'b0,
  localparam int WIN_W          = win_width(NUM_WINDOWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_left,
  input  logic             btn_center,
  input  logic             btn_right,
  input  logic             calc_done,
  output logic             load_initial,
  output logic             calculating,
  output logic [WIN_W-1:0] window_sel
);

  localparam logic [WIN_W-1:0] IDX_FIRST = WIN_W'(1);
  localparam logic [WIN_W-1:0] IDX_LAST  = WIN_W'(NUM_WINDOWS);
  localparam logic [WIN_W-1:0] IDX_BLANK = WIN_W'(WIN_BLANK);

  state_t           state;
  state_t           state_next;
  logic [WIN_W-1:0] index;
  logic [WIN_W-1:0] index_next;
  logic             calculating_next;
  logic             load_next;
  logic [WIN_W-1:0] window_next;

  logic             left_press;
  logic             center_press;
  logic             right_press;
  logic [2:0]       unused_levels;

  // One conditioner per button; only the press pulses drive the FSM.
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_left),
    .level (unused_levels[0]),
    .press (left_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_center (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_center),
    .level (unused_levels[1]),
    .press (center_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_right),
    .level (unused_levels[2]),
    .press (right_press)
  );

  // State, index and all outputs are flops, so nothing combinational
  // reaches the datapath or the display mux from the buttons.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      index        <= IDX_FIRST;
      calculating  <= 1'b0;
      load_initial <= 1'b0;
      window_sel   <= IDX_BLANK;
    end else begin
      state        <= state_next;
      index        <= index_next;
      calculating  <= calculating_next;
      load_initial <= load_next;
      window_sel   <= window_next;
    end
  end

  // Next-state logic. Centre wins over everything, including a pending
  // calc_done or simultaneous scroll presses. The registered outputs are
  // derived from the next state so they line up with it.
  always_comb begin
    state_next       = state;
    index_next       = index;
    calculating_next = calculating;

    if (center_press) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        LOAD: begin
          // calc_done is still the previous result here, so it is ignored.
          state_next       = CALC;
          index_next       = IDX_FIRST;
          calculating_next = 1'b1;
        end
        CALC: begin
          if (calc_done) begin
            state_next       = SHOW;
            calculating_next = 1'b0;
          end
        end
        SHOW: begin
          if (!calc_done) begin
            state_next = CALC;
          end else if (left_press && !right_press) begin
            if (index == IDX_LAST) begin
              index_next = WRAP ? IDX_FIRST : index;
            end else begin
              index_next = index + WIN_W'(1);
            end
          end else if (right_press && !left_press) begin
            if (index == IDX_FIRST) begin
              index_next = WRAP ? IDX_LAST : index;
            end else begin
              index_next = index - WIN_W'(1);
            end
          end
        end
      endcase
    end

    load_next   = (state_next == LOAD);
    window_next = (state_next == SHOW) ? index_next : IDX_BLANK;
  end

endmodule
